bit_serial_adder_ctrl: RTL and testbench

BIT_SERIAL_ADDER_CTRL -- requirements
Module: bit_serial_adder_ctrl

---
 rtl/bit_serial_adder_ctrl.sv | 97 +++++++++
 tb/tb_bit_serial_adder_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder stage walks the operands LSB first,
// one bit per clock, then publishes sum/cout with a one-cycle done pulse.
module bit_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;

  logic             w_aBit;
  logic             w_bBit;
  logic             w_sumBit;
  logic             w_carryNext;
  logic             w_lastBit;
  logic [WIDTH-1:0] w_resultNext;

  assign w_aBit      = r_a[r_cnt];
  assign w_bBit      = r_b[r_cnt];
  assign w_sumBit    = w_aBit ^ w_bBit ^ r_carry;
  assign w_carryNext = (w_aBit & w_bBit) | (w_aBit & r_carry) | (w_bBit & r_carry);
  assign w_lastBit   = (r_cnt == CW'(WIDTH - 1));

  // Result with the current bit folded in, so the final bit reaches sum on the DONE edge.
  always_comb begin
    w_resultNext        = r_result;
    w_resultNext[r_cnt] = w_sumBit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_carry  <= cin;
            r_cnt    <= '0;
            r_result <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_result <= w_resultNext;
          r_carry  <= w_carryNext;
          r_cnt    <= r_cnt + CW'(1);
          if (w_lastBit) begin
            r_sum   <= w_resultNext;
            r_cout  <= w_carryNext;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Directed vector bench for bit_serial_adder_ctrl at WIDTH=8: table-driven
// additions plus hand-written abort, mid-run and back-to-back sequences.
module tb_bit_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] expSum;
    logic       expCout;
  } vec_t;

  vec_t vecs[8];
  vec_t held[3];

  bit_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Pulse start for one accept edge, then count edges until done appears.
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vcin,
                               output int latency, output int busyCnt);
    @(negedge clk);
    a = va; b = vb; cin = vcin; start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    latency = 0;
    busyCnt = 0;
    while (!done && latency < 40) begin
      if (busy) busyCnt++;
      @(posedge clk); #1;
      latency++;
    end
  endtask

  initial begin
    int lat, bcnt, doneCnt, k, t, lastT;
    logic [7:0] capSum;
    logic       capCout;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

    held[0] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    held[1] = '{8'hF0, 8'h20, 1'b1, 8'h11, 1'b1};
    held[2] = '{8'h55, 8'h55, 1'b0, 8'hAA, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_sum",  sum,  0);
    checkOutput("reset_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcnt);
      checkOutput($sformatf("vec%0d_latency", i), lat, WIDTH);
      checkOutput($sformatf("vec%0d_busyCycles", i), bcnt, WIDTH);
      checkOutput($sformatf("vec%0d_sum", i), sum, vecs[i].expSum);
      checkOutput($sformatf("vec%0d_cout", i), cout, vecs[i].expCout);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_donePulse", i), done, 0);
      checkOutput($sformatf("vec%0d_sumHold", i), sum, vecs[i].expSum);
    end

    // Operand change and a stray start while RUN must not disturb the result.
    @(negedge clk);
    a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    doneCnt = 0; capSum = '0; capCout = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        doneCnt++;
        capSum  = sum;
        capCout = cout;
      end
    end
    checkOutput("midrun_doneCount", doneCnt, 1);
    checkOutput("midrun_sum", capSum, 8'h4B);
    checkOutput("midrun_cout", capCout, 0);

    // Asynchronous reset during the 4th RUN cycle aborts the operation.
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_sum",  sum,  0);
    checkOutput("abort_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) doneCnt++;
    end
    checkOutput("abort_noDone", doneCnt, 0);
    applyStimulus(8'h01, 8'h01, 1'b0, lat, bcnt);
    checkOutput("postReset_latency", lat, WIDTH);
    checkOutput("postReset_sum", sum, 8'h02);
    checkOutput("postReset_cout", cout, 0);
    @(posedge clk); #1;

    // start held high: operations every WIDTH+2 cycles, each using its accept-edge operands.
    @(negedge clk);
    a = held[0].a; b = held[0].b; cin = held[0].cin; start = 1'b1;
    k = 0; t = 0; lastT = 0;
    while (k < 3 && t < 60) begin
      @(posedge clk); #1;
      t++;
      if (done) begin
        checkOutput($sformatf("held%0d_sum", k), sum, held[k].expSum);
        checkOutput($sformatf("held%0d_cout", k), cout, held[k].expCout);
        if (k > 0) checkOutput($sformatf("held%0d_spacing", k), t - lastT, WIDTH + 2);
        lastT = t;
        k++;
        if (k < 3) begin
          a = held[k].a; b = held[k].b; cin = held[k].cin;
        end else begin
          start = 1'b0;
        end
      end
    end
    checkOutput("held_opCount", k, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
